// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and default sizes for the multi-port register bank
package reg_bank_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam int REG_BANK_DATA_W = 32;
  localparam int REG_BANK_DEPTH  = 32;
  localparam int REG_BANK_NUM_RD = 2;

endpackage

// File: rtl/reg_bank_clr_seq.sv
// rtl/reg_bank_clr_seq.sv - sequenced clear engine: walks the array one entry per cycle
module reg_bank_clr_seq
  import reg_bank_pkg::*;
#(
  parameter int DEPTH  = REG_BANK_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  // The counter parks on the last entry when the sweep ends; it is reloaded on the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CLR_IDLE: begin
          if (clr_req) begin
            state_q <= CLR_RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLR_RUN: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= CLR_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign clr_we   = (state_q == CLR_RUN);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - parametrised multi-port register bank with sequenced clear
// Same-cycle write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = REG_BANK_DATA_W,
  parameter int DEPTH    = REG_BANK_DEPTH,
  parameter int NUM_RD   = REG_BANK_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_go;

  // An address is usable if it exists in the array and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  reg_bank_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes are only honoured while the clear engine is idle; a write during a sweep is dropped.
  assign wr_go = wr_en && !clr_we && addr_ok(wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_go) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      if (addr_ok(addr)) begin
        data = mem_q[addr];
`ifdef REG_BANK_BYPASS_EN
        if (wr_go && (wr_addr == addr)) begin
          data = wr_data;
        end
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

endmodule
